sliding_window: RTL and testbench
=================================

Name:
sliding_window

Overview:
- Streaming 2-D window generator for raster-scan image data, e.g. luma pixels feeding feature or corner detectors.
- Accepts one pixel per valid cycle, buffers the previous WINDOW_NUM_ROWS-1 image rows in internal line buffers, and presents a registered WINDOW_NUM_ROWS x WINDOW_NUM_COLS window.
- The bottom-right element of the window is always the most recently accepted pixel.
- The row length is programmable at run time, up to MAX_ROW_LENGTH.

Parameters:
- DATA_BITS, 8, width of one pixel.
- WINDOW_NUM_ROWS, 3, window height; must be >= 2.
- WINDOW_NUM_COLS, 3, window width; must be >= 1.
- MAX_ROW_LENGTH, 640, depth of each line buffer (maximum pixels per row).
- COORD_BITS, 10, width of the column counter and of r_row_length.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- r_row_length  input  COORD_BITS  pixels per image row. Legal range is 2..min(MAX_ROW_LENGTH, 2^COORD_BITS-1). Must be held stable while in_valid can be asserted.
- in_valid  input  1  qualifies in_data; one pixel is accepted per clock while high.
- in_data  input  DATA_BITS  pixel, in raster order.
- out_window  output  array [WINDOW_NUM_ROWS][WINDOW_NUM_COLS] of DATA_BITS  current window.
  - Index [0][0] is the oldest row and leftmost column (top-left).
  - Index [ROWS-1][COLS-1] is the newest pixel (bottom-right).

Behaviour:
- Reset (reset=0, asynchronous):
  - Column counter = 0.
  - Every out_window element = 0.
  - Every line-buffer entry = 0.
- Acceptance: on a rising clk edge with in_valid=1 and reset=1, let col = column counter value and L[k] = line buffer k (k=0 is the most recent previous row).
  - Horizontal shift: out_window[r][c] <= out_window[r][c+1] for c < COLS-1.
  - New right column:
    - out_window[ROWS-1][COLS-1] <= in_data.
    - out_window[ROWS-2-k][COLS-1] <= L[k][col], using the old (pre-write) contents.
  - Line-buffer cascade:
    - L[0][col] <= in_data.
    - L[k][col] <= old L[k-1][col] for k >= 1.
  - Column counter: if col == r_row_length-1 it wraps to 0; otherwise it increments.
- Latency: out_window reflects a pixel on the clock edge that accepts it. There is no additional pipeline delay, and the output comes straight from registers.
- Result: after pixel (y, x) is accepted, out_window[r][c] = pixel(y-(ROWS-1)+r, x-(COLS-1)+c).
- in_valid=0: all state holds, and out_window is unchanged.
- No edge masking:
  - At the start of a row, the left columns still hold the previous row's tail pixels.
  - During the first ROWS-1 rows, the upper rows show line-buffer contents (zeros after reset).
  - Downstream logic qualifies these positions itself.
- No frame counter: the stream is continuous across frames. Apply reset between frames for clean zero-filled boundaries.
- Reset mid-row discards the partial row: the counter returns to 0 and all storage clears.

Optional Feature:
- Macro: SLIDING_WINDOW_VALID_EN.
- When defined:
  - Adds a row counter (COORD_BITS wide, saturating) and an output out_valid (1 bit, registered, reset 0).
  - On each accepted pixel at (row y, col x), out_valid <= (y >= ROWS-1) && (x >= COLS-1).
  - out_valid holds when in_valid=0.
  - The row counter increments when the column counter wraps, and clears on reset.
- When undefined: no row counter and no out_valid port. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: with reset=0, every out_window element = 0. After release with in_valid=0 for 5 cycles, out_window stays 0.
- 2x2 window, r_row_length=12, 12x12 image:
  - Image is all 0xFF except row 6 = ff×5,aa,00×6; row 7 = ff×5,55,00×6; row 8 = ff×4,aa,00×7; row 9 = ff×4,55,00×7; row 10 = ff×3,aa,00×8; row 11 = ff×3,55,00×8.
  - After exactly 102 pixels are accepted, out_window = {{ff,55},{aa,00}}.
- Ramp image, pixel value = index, 2x2 window, r_row_length=12: after 26 pixels, out_window = {{12,13},{24,25}}. After 14 pixels, out_window = {{0,1},{12,13}}.
- Gaps: the ramp stream with in_valid deasserted for 3 cycles between every pixel gives the same windows at the same pixel counts as the unbroken stream.
- Reset mid-row: after 30 ramp pixels, assert reset for 1 cycle, then resend the ramp from 0. After 14 pixels, out_window = {{0,1},{12,13}}.
- SLIDING_WINDOW_VALID_EN, 3x3, r_row_length=12: out_valid first = 1 after pixel index 26 (row 2, col 2). It goes 0 at col 0 and col 1 of each subsequent row.

Source files
------------

// File: rtl/sliding_window.sv
// Streaming 2-D window generator; optional out_valid via SLIDING_WINDOW_VALID_EN.
// Zero latency (window registered on the accepting edge); no backpressure, in_valid=0 holds all state.
module sliding_window #(
    parameter int DATA_BITS       = 8,
    parameter int WINDOW_NUM_ROWS = 3,
    parameter int WINDOW_NUM_COLS = 3,
    parameter int MAX_ROW_LENGTH  = 640,
    parameter int COORD_BITS      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COORD_BITS-1:0] r_row_length,
    input  logic                  in_valid,
    input  logic [DATA_BITS-1:0]  in_data,
    output logic [DATA_BITS-1:0]  out_window [WINDOW_NUM_ROWS][WINDOW_NUM_COLS]
`ifdef SLIDING_WINDOW_VALID_EN
    ,
    output logic                  out_valid
`endif
);

    localparam int NLB = WINDOW_NUM_ROWS - 1;

    logic [DATA_BITS-1:0]  lb_q  [NLB][MAX_ROW_LENGTH];
    logic [DATA_BITS-1:0]  lb_rd [NLB];
    logic [DATA_BITS-1:0]  win_q [WINDOW_NUM_ROWS][WINDOW_NUM_COLS];
    logic [DATA_BITS-1:0]  win_d [WINDOW_NUM_ROWS][WINDOW_NUM_COLS];
    logic [COORD_BITS-1:0] col_q, col_d;
    logic                  col_wrap;

    always_comb begin
        col_wrap = (col_q == (r_row_length - COORD_BITS'(1)));
        for (int k = 0; k < NLB; k++) begin
            lb_rd[k] = lb_q[k][col_q];
        end
    end

    always_comb begin
        win_d = win_q;
        col_d = col_q;
        if (in_valid) begin
            for (int r = 0; r < WINDOW_NUM_ROWS; r++) begin
                for (int c = 0; c < WINDOW_NUM_COLS - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            // Right column: newest pixel at the bottom, older rows from the line buffers above it.
            win_d[WINDOW_NUM_ROWS-1][WINDOW_NUM_COLS-1] = in_data;
            for (int k = 0; k < NLB; k++) begin
                win_d[WINDOW_NUM_ROWS-2-k][WINDOW_NUM_COLS-1] = lb_rd[k];
            end
            col_d = col_wrap ? '0 : col_q + COORD_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            for (int r = 0; r < WINDOW_NUM_ROWS; r++) begin
                for (int c = 0; c < WINDOW_NUM_COLS; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q <= col_d;
            win_q <= win_d;
        end
    end

    // Cascade: each buffer takes the previous one's old value at the same column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NLB; k++) begin
                for (int i = 0; i < MAX_ROW_LENGTH; i++) begin
                    lb_q[k][i] <= '0;
                end
            end
        end else if (in_valid) begin
            lb_q[0][col_q] <= in_data;
            for (int k = 1; k < NLB; k++) begin
                lb_q[k][col_q] <= lb_q[k-1][col_q];
            end
        end
    end

    assign out_window = win_q;

`ifdef SLIDING_WINDOW_VALID_EN
    logic [COORD_BITS-1:0] row_q, row_d;
    logic                  out_valid_q, out_valid_d;

    always_comb begin
        row_d       = row_q;
        out_valid_d = out_valid_q;
        if (in_valid) begin
            out_valid_d = (row_q >= COORD_BITS'(WINDOW_NUM_ROWS - 1)) &&
                          (col_q >= COORD_BITS'(WINDOW_NUM_COLS - 1));
            if (col_wrap && (row_q != '1)) begin
                row_d = row_q + COORD_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_sliding_window.sv
// Self-checking bench: 2x2 and 3x3 instances driven in parallel against a linear-index reference model.
module tb_sliding_window;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] r_row_length;
    logic       in_valid;
    logic [7:0] in_data;
    logic [7:0] win2 [2][2];
    logic [7:0] win3 [3][3];
`ifdef SLIDING_WINDOW_VALID_EN
    logic       ov2, ov3;
`endif

    always #5 clk = ~clk;

    sliding_window #(.DATA_BITS(8), .WINDOW_NUM_ROWS(2), .WINDOW_NUM_COLS(2),
                     .MAX_ROW_LENGTH(640), .COORD_BITS(10)) dut2 (
        .clk(clk), .reset(reset), .r_row_length(r_row_length),
        .in_valid(in_valid), .in_data(in_data), .out_window(win2)
`ifdef SLIDING_WINDOW_VALID_EN
        , .out_valid(ov2)
`endif
    );

    sliding_window #(.DATA_BITS(8), .WINDOW_NUM_ROWS(3), .WINDOW_NUM_COLS(3),
                     .MAX_ROW_LENGTH(640), .COORD_BITS(10)) dut3 (
        .clk(clk), .reset(reset), .r_row_length(r_row_length),
        .in_valid(in_valid), .in_data(in_data), .out_window(win3)
`ifdef SLIDING_WINDOW_VALID_EN
        , .out_valid(ov3)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned hist[$];
    int          L = 12;
    logic        ev2 = 1'b0, ev3 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Element [r][c] is the pixel (ROWS-1-r) rows and (COLS-1-c) columns before the newest one.
    function automatic int unsigned model_px(int R, int C, int r, int c);
        int n;
        int idx;
        n   = hist.size() - 1;
        idx = n - (R - 1 - r) * L - (C - 1 - c);
        return (idx < 0) ? 0 : hist[idx];
    endfunction

    task automatic check_all(input string tag);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                check($sformatf("%s w2[%0d][%0d]", tag, r, c), 32'(win2[r][c]), model_px(2, 2, r, c));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("%s w3[%0d][%0d]", tag, r, c), 32'(win3[r][c]), model_px(3, 3, r, c));
`ifdef SLIDING_WINDOW_VALID_EN
        check($sformatf("%s ov2", tag), 32'(ov2), 32'(ev2));
        check($sformatf("%s ov3", tag), 32'(ov3), 32'(ev3));
`endif
    endtask

    task automatic step(input bit v, input logic [7:0] d, input string tag);
        int n;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        if (v) begin
            n   = hist.size();
            ev2 = ((n / L) >= 1) && ((n % L) >= 1);
            ev3 = ((n / L) >= 2) && ((n % L) >= 2);
            hist.push_back(32'(d));
        end
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles, input int len);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        hist.delete();
        ev2 = 1'b0;
        ev3 = 1'b0;
        #1;
        check_all("rst");
        repeat (cycles) @(negedge clk);
        r_row_length = 10'(len);
        L            = len;
        reset        = 1'b1;
    endtask

    function automatic logic [7:0] img_px(int y, int x);
        int nff;
        if (y < 6) return 8'hff;
        nff = 5 - (y - 6) / 2;
        if (x < nff) return 8'hff;
        if (x == nff) return (y % 2 == 0) ? 8'haa : 8'h55;
        return 8'h00;
    endfunction

    task automatic ramp(input int count, input int gap);
        for (int p = 0; p < count; p++) begin
            step(1'b1, 8'(p), "ramp");
            if (p == 13) begin
                check("ramp14 [0][0]", 32'(win2[0][0]), 32'd0);
                check("ramp14 [0][1]", 32'(win2[0][1]), 32'd1);
                check("ramp14 [1][0]", 32'(win2[1][0]), 32'd12);
                check("ramp14 [1][1]", 32'(win2[1][1]), 32'd13);
            end
            if (p == 25 && count > 25) begin
                check("ramp26 [0][0]", 32'(win2[0][0]), 32'd12);
                check("ramp26 [0][1]", 32'(win2[0][1]), 32'd13);
                check("ramp26 [1][0]", 32'(win2[1][0]), 32'd24);
                check("ramp26 [1][1]", 32'(win2[1][1]), 32'd25);
            end
`ifdef SLIDING_WINDOW_VALID_EN
            if (p == 25) check("ov3 before 26", 32'(ov3), 32'd0);
            if (p == 26) check("ov3 first at 26", 32'(ov3), 32'd1);
            if (p == 36 || p == 37) check("ov3 row3 col0/1", 32'(ov3), 32'd0);
`endif
            for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), "gap");
        end
    endtask

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        r_row_length = 10'd12;
        repeat (2) @(negedge clk);
        check_all("in reset");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, "idle");

        // Patterned 12x12 image
        do_reset(1, 12);
        for (int p = 0; p < 102; p++) step(1'b1, img_px(p / 12, p % 12), "img");
        check("img [0][0]", 32'(win2[0][0]), 32'hff);
        check("img [0][1]", 32'(win2[0][1]), 32'h55);
        check("img [1][0]", 32'(win2[1][0]), 32'haa);
        check("img [1][1]", 32'(win2[1][1]), 32'h00);

        do_reset(1, 12);
        ramp(40, 0);
        do_reset(1, 12);
        ramp(30, 3);
        do_reset(1, 12);
        ramp(30, 0);
        do_reset(1, 12);
        ramp(14, 0);

        for (int round = 0; round < 6; round++) begin
            int len;
            len = $urandom_range(2, 16);
            do_reset(1 + $urandom_range(0, 2), len);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 199) == 0) do_reset(1, len);
                step($urandom_range(0, 3) != 0, 8'($urandom), "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
